// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every handshake/bus signal of mem_port_arbiter: the instruction
// fetch requester (if_*), the load/store requester (ls_*), the unified memory
// port (mem_*) and the status outputs (busy, owner).
//
// Modports:
//   master - the arbiter: drives grants, responses, the memory request side
//            and status; samples requests and memory responses.
//   slave  - the surroundings (fetch/LSU logic and memory model): the mirror.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);

  // Instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  // Load/store requester
  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [31:0]       ls_rdata;

  // Unified memory port
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  // Status
  logic              busy;
  logic              owner;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output busy, owner
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  busy, owner
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between instruction fetch (IF) and the
// load/store path (LS). Fixed priority LS > IF, one transaction in flight.
// A three-state FSM (IDLE -> REQ -> WAIT -> IDLE) issues the request, waits
// for memory to accept it, then waits for the response and routes it back
// to the requester that owns the transaction.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - mem_port_arbiter_if.master: if_* / ls_* requester handshakes,
//            mem_* memory port, busy / owner status
//
// Parameters:
//   MAX_LOSSES - consecutive arbitration losses IF may suffer before it is
//                forced to win (1..15, starvation guard only)
//   ADDR_W     - address width, must match the interface instance
//
// Build option:
//   ARB_STARVE_GUARD_EN - when defined, a saturating loss counter lets IF win
//                         after MAX_LOSSES consecutive losses to LS. When not
//                         defined, priority is strictly LS > IF.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MAX_LOSSES = 4,
  parameter int ADDR_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus
);

  if (MAX_LOSSES < 1 || MAX_LOSSES > 15) begin : g_bad_max_losses
    $error("mem_port_arbiter: MAX_LOSSES must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [1:0]        mem_size_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              owner_q;

  logic any_req;
  logic pick_ls;
  logic accept;
  logic finish;

  assign any_req = bus.if_req | bus.ls_req;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LOSS_MAX = 4'(MAX_LOSSES);

  logic [3:0] loss_cnt;
  logic       if_forced;

  assign if_forced = bus.if_req && (loss_cnt == LOSS_MAX);
  assign pick_ls   = bus.ls_req && !if_forced;

  // Counts IDLE arbitrations that IF lost to LS; any IF win restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (!pick_ls) begin
        loss_cnt <= '0;
      end else if (bus.if_req && loss_cnt != LOSS_MAX) begin
        loss_cnt <= loss_cnt + 4'd1;
      end
    end
  end
`else
  assign pick_ls = bus.ls_req;
`endif

  // mem_rvalid only counts once memory has accepted the current request;
  // responses in IDLE or in REQ without mem_ready are stale and dropped.
  // NOTE: the pulses are qualified with rst_n because reset is synchronous:
  // during the reset cycle the state register still holds REQ/WAIT, and an
  // aborted transaction must not see a grant or response.
  assign accept = rst_n && (state == REQ) && bus.mem_ready;
  assign finish = rst_n && ((accept && bus.mem_rvalid) ||
                            ((state == WAIT) && bus.mem_rvalid));

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the same pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= REQ;
            mem_req_q <= 1'b1;
            owner_q   <= pick_ls;
            if (pick_ls) begin
              mem_we_q    <= bus.ls_we;
              mem_size_q  <= bus.ls_size;
              mem_addr_q  <= bus.ls_addr;
              mem_wdata_q <= bus.ls_wdata;
            end else begin
              // Fetches are always word reads.
              mem_we_q    <= 1'b0;
              mem_size_q  <= 2'd2;
              mem_addr_q  <= bus.if_addr;
              mem_wdata_q <= '0;
            end
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            // Zero-latency memory answers in the accept cycle; skip WAIT.
            state     <= bus.mem_rvalid ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory port and status
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = rst_n && (state != IDLE);

  // Grants and responses go only to the owner of the transaction.
  assign bus.if_gnt    = accept && !owner_q;
  assign bus.ls_gnt    = accept &&  owner_q;
  assign bus.if_rvalid = finish && !owner_q;
  assign bus.ls_rvalid = finish &&  owner_q;

  // A store's write acknowledge carries no data back to LS.
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'd0;
  assign bus.ls_rdata  = (bus.ls_rvalid && !mem_we_q) ? bus.mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed stimulus for mem_port_arbiter. Each test pushes the grants and
// responses it expects (owner, cycle, memory fields, data) into a queue; a
// negedge monitor pops and compares whenever the arbiter pulses a gnt or
// rvalid. A few state checks (busy, mem_req, owner) are made in-line.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;

  typedef struct {
    bit          rv;     // 0 = grant, 1 = response
    bit          ls;     // 0 = IF, 1 = LS
    int unsigned cyc;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        sb[$];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(
    .MAX_LOSSES(4),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_gnt(input bit ls, input int unsigned c, input logic [31:0] addr,
                          input logic we, input logic [1:0] size, input logic [31:0] wdata);
    exp_t e;
    e.rv = 1'b0; e.ls = ls; e.cyc = c; e.rdata = '0;
    e.addr = addr; e.we = we; e.size = size; e.wdata = wdata;
    sb.push_back(e);
  endtask

  task automatic push_rv(input bit ls, input int unsigned c, input logic [31:0] rdata);
    exp_t e;
    e.rv = 1'b1; e.ls = ls; e.cyc = c; e.rdata = rdata;
    e.addr = '0; e.we = 1'b0; e.size = '0; e.wdata = '0;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input bit rv, input bit ls);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL sb_unexpected: %s %s pulse at cycle %0d, nothing expected",
               ls ? "ls" : "if", rv ? "rvalid" : "gnt", cyc);
    end else begin
      e = sb.pop_front();
      check("sb_kind_rv_ls", {62'd0, rv, ls}, {62'd0, e.rv, e.ls});
      check("sb_cycle", 64'(cyc), 64'(e.cyc));
      if (rv) begin
        check("sb_rdata", ls ? bus.ls_rdata : bus.if_rdata, e.rdata);
      end else begin
        check("sb_mem_addr",  bus.mem_addr,  e.addr);
        check("sb_mem_we",    bus.mem_we,    e.we);
        check("sb_mem_size",  bus.mem_size,  e.size);
        check("sb_mem_wdata", bus.mem_wdata, e.wdata);
      end
    end
  endtask

  // Monitor: compares every grant/response pulse against the scoreboard.
  always @(negedge clk) begin
    if (bus.if_gnt)    pop_cmp(1'b0, 1'b0);
    if (bus.ls_gnt)    pop_cmp(1'b0, 1'b1);
    if (bus.if_rvalid) pop_cmp(1'b1, 1'b0);
    if (bus.ls_rvalid) pop_cmp(1'b1, 1'b1);
    if (!bus.if_rvalid) check("if_rdata_zero", bus.if_rdata, 0);
    if (!bus.ls_rvalid) check("ls_rdata_zero", bus.ls_rdata, 0);
  end

  int unsigned t0;
  bit          exp_ls;

  initial begin
    rst_n          = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.ls_req     = 1'b0;
    bus.ls_we      = 1'b0;
    bus.ls_size    = 2'd0;
    bus.ls_addr    = '0;
    bus.ls_wdata   = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    // ---- Reset state
    step(2);
    rst_n = 1'b1;
    step(1);
    check("rst_busy",      bus.busy,      0);
    check("rst_mem_req",   bus.mem_req,   0);
    check("rst_mem_we",    bus.mem_we,    0);
    check("rst_mem_size",  bus.mem_size,  0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_owner",     bus.owner,     0);

    // ---- 1: single fetch, ready at once, rvalid two cycles after accept
    t0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.mem_ready = 1'b1;
    push_gnt(1'b0, t0 + 1, 32'h100, 1'b0, 2'd2, 32'h0);
    push_rv (1'b0, t0 + 3, 32'h0050_0093);
    step(1);
    check("t1_mem_req_c1", bus.mem_req, 1);
    check("t1_owner_c1",   bus.owner,   0);
    step(1);
    bus.if_req = 1'b0;
    check("t1_mem_req_c2", bus.mem_req, 0);
    check("t1_busy_c2",    bus.busy,    1);
    step(1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0050_0093;
    step(1);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    check("t1_busy_c4", bus.busy, 0);

    // ---- 2: simultaneous requests, LS first, IF after the bubble
    t0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd2;
    bus.ls_addr = 32'h2000; bus.ls_wdata = 32'h5555_5555;
    push_gnt(1'b1, t0 + 1, 32'h2000, 1'b0, 2'd2, 32'h5555_5555);
    push_rv (1'b1, t0 + 2, 32'h1122_3344);
    push_gnt(1'b0, t0 + 4, 32'h200, 1'b0, 2'd2, 32'h0);
    push_rv (1'b0, t0 + 5, 32'hCAFE_F00D);
    step(1);
    check("t2_owner_ls", bus.owner, 1);
    step(1);
    bus.ls_req = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1122_3344;
    step(1);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    step(1);
    check("t2_owner_if", bus.owner, 0);
    step(1);
    bus.if_req = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    step(1);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    check("t2_busy_end", bus.busy, 0);

    // ---- 3: byte store, ready delayed 3 cycles, stale rvalid ignored in REQ
    t0 = cyc;
    bus.mem_ready = 1'b0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd0;
    bus.ls_addr = 32'h3003; bus.ls_wdata = 32'hAB;
    push_gnt(1'b1, t0 + 4, 32'h3003, 1'b1, 2'd0, 32'hAB);
    push_rv (1'b1, t0 + 6, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      bus.mem_rvalid = (k == 2);
      check("t3_hold_mem_req",   bus.mem_req,   1);
      check("t3_hold_mem_addr",  bus.mem_addr,  32'h3003);
      check("t3_hold_mem_we",    bus.mem_we,    1);
      check("t3_hold_mem_size",  bus.mem_size,  0);
      check("t3_hold_mem_wdata", bus.mem_wdata, 32'hAB);
    end
    step(1);
    bus.mem_rvalid = 1'b0;
    bus.mem_ready = 1'b1;
    check("t3_mem_req_c4", bus.mem_req, 1);
    step(1);
    bus.ls_req = 1'b0; bus.ls_we = 1'b0;
    step(1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    step(1);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    check("t3_busy_end", bus.busy, 0);

    // ---- 4: zero-latency memory (rvalid already high in IDLE is ignored)
    t0 = cyc;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd1;
    bus.ls_addr = 32'h40; bus.ls_wdata = 32'h0;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_BEEF;
    push_gnt(1'b1, t0 + 1, 32'h40, 1'b0, 2'd1, 32'h0);
    push_rv (1'b1, t0 + 1, 32'h0000_BEEF);
    step(1);
    step(1);
    bus.ls_req = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    check("t4_busy_next",    bus.busy,    0);
    check("t4_mem_req_next", bus.mem_req, 0);
    step(1);
    check("t4_busy_after", bus.busy, 0);

    // ---- 5: reset while in WAIT, late rvalid must go nowhere
    t0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    push_gnt(1'b0, t0 + 1, 32'h500, 1'b0, 2'd2, 32'h0);
    step(1);
    step(1);
    bus.if_req = 1'b0;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0777;
    check("t5_busy",    bus.busy,    0);
    check("t5_mem_req", bus.mem_req, 0);
    check("t5_owner",   bus.owner,   0);
    check("t5_mem_addr", bus.mem_addr, 0);
    step(1);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    check("t5_busy_after", bus.busy, 0);

    // ---- 6: both requesters held high, zero-latency memory
    t0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h800;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd2;
    bus.ls_addr = 32'h7000; bus.ls_wdata = 32'h0;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_600D;
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_ls = (i % 5) != 4;
`else
      exp_ls = 1'b1;
`endif
      push_gnt(exp_ls, t0 + 1 + 2 * i, exp_ls ? 32'h7000 : 32'h800, 1'b0, 2'd2, 32'h0);
      push_rv (exp_ls, t0 + 1 + 2 * i, 32'h0000_600D);
    end
    step(19);
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    step(1);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    check("t6_busy_end", bus.busy, 0);
    step(1);
    check("t6_mem_req_end", bus.mem_req, 0);

    // ---- Every expected pulse must have been seen
    step(3);
    check("sb_drained", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
